// File: rtl/sample_serializer_pkg.sv
// Shared configuration for the sample serializer: record geometry and FSM states.
package sample_serializer_pkg;

    localparam int RECORD_BYTES_DEF = 6;
    localparam int BYTE_W           = 8;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

endpackage

// File: rtl/record_holding_reg.sv
// One-entry holding buffer for the record queued behind the one being sent.
module record_holding_reg #(
    parameter int W = 48
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         take,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         valid
);

    logic [W-1:0] data_r;
    logic         valid_r;

    // Capture on load; take only clears the flag. Load wins if both fire.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_r  <= {W{1'b0}};
            valid_r <= 1'b0;
        end else if (load) begin
            data_r  <= din;
            valid_r <= 1'b1;
        end else if (take) begin
            valid_r <= 1'b0;
        end
    end

    assign dout  = data_r;
    assign valid = valid_r;

endmodule

// File: rtl/sample_serializer.sv
// Byte serializer feeding the FX2 sample path: one record in flight, one buffered.
module sample_serializer
    import sample_serializer_pkg::*;
#(
    parameter int RECORD_BYTES = RECORD_BYTES_DEF,
    parameter int CNT_W        = 32
) (
    input  logic                           fx2_clk,
    input  logic                           reset,
    input  logic                           enable,
    input  logic [BYTE_W*RECORD_BYTES-1:0] rec_in,
    input  logic                           rec_valid,
    output logic                           rec_ready,
    output logic [BYTE_W-1:0]              sample,
    output logic                           sample_rdy,
    input  logic                           sample_ack,
    output logic [CNT_W-1:0]               records_sent,
    output logic                           idle
);

    localparam int REC_W = BYTE_W * RECORD_BYTES;
    localparam int IDX_W = (RECORD_BYTES > 1) ? $clog2(RECORD_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RECORD_BYTES - 1);

    state_t            state_r, state_nxt_s;
    logic [REC_W-1:0]  cur_rec_r, cur_rec_nxt_s;
    logic [IDX_W-1:0]  byte_idx_r, byte_idx_nxt_s;
    logic [CNT_W-1:0]  records_sent_r;
    logic              idle_r;

    logic              accept_s;
    logic              ack_s;
    logic              last_s;
    logic              load_s;
    logic              take_s;
    logic              cnt_inc_s;
    logic              next_valid_s;
    logic              next_valid_nxt_s;
    logic [REC_W-1:0]  next_rec_s;

    // Buffered record slot behind the one currently shifting out.
    record_holding_reg #(.W(REC_W)) u_next (
        .clk   (fx2_clk),
        .reset (reset),
        .load  (load_s),
        .take  (take_s),
        .din   (rec_in),
        .dout  (next_rec_s),
        .valid (next_valid_s)
    );

    // Ready only looks at enable and the buffer slot, never at the consumer.
    assign rec_ready = enable && !next_valid_s;
    assign accept_s  = rec_valid && rec_ready;
    assign ack_s     = sample_ack && (state_r == S_SEND);
    assign last_s    = (byte_idx_r == LAST_IDX);

    // Next-state, shift and buffer steering decisions.
    always_comb begin
        state_nxt_s    = state_r;
        cur_rec_nxt_s  = cur_rec_r;
        byte_idx_nxt_s = byte_idx_r;
        load_s         = 1'b0;
        take_s         = 1'b0;
        cnt_inc_s      = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (accept_s) begin
                    cur_rec_nxt_s  = rec_in;
                    byte_idx_nxt_s = {IDX_W{1'b0}};
                    state_nxt_s    = S_SEND;
                end else begin
                    state_nxt_s    = S_IDLE;
                end
            end
            S_SEND: begin
                if (ack_s && last_s) begin
                    cnt_inc_s      = 1'b1;
                    byte_idx_nxt_s = {IDX_W{1'b0}};
                    if (next_valid_s) begin
                        // Buffered record follows with no bubble.
                        cur_rec_nxt_s = next_rec_s;
                        take_s        = 1'b1;
                    end else if (accept_s) begin
                        cur_rec_nxt_s = rec_in;
                    end else begin
                        cur_rec_nxt_s = {REC_W{1'b0}};
                        state_nxt_s   = S_IDLE;
                    end
                end else if (ack_s) begin
                    cur_rec_nxt_s  = cur_rec_r >> BYTE_W;
                    byte_idx_nxt_s = byte_idx_r + IDX_W'(1);
                    load_s         = accept_s;
                end else begin
                    load_s         = accept_s;
                end
            end
            default: begin
                state_nxt_s    = S_IDLE;
                cur_rec_nxt_s  = {REC_W{1'b0}};
                byte_idx_nxt_s = {IDX_W{1'b0}};
            end
        endcase
        next_valid_nxt_s = load_s || (next_valid_s && !take_s);
    end

    // Current record, byte position, FSM state, status counter and idle flag.
    always_ff @(posedge fx2_clk or posedge reset) begin
        if (reset) begin
            state_r        <= S_IDLE;
            cur_rec_r      <= {REC_W{1'b0}};
            byte_idx_r     <= {IDX_W{1'b0}};
            records_sent_r <= {CNT_W{1'b0}};
            idle_r         <= 1'b1;
        end else begin
            state_r    <= state_nxt_s;
            cur_rec_r  <= cur_rec_nxt_s;
            byte_idx_r <= byte_idx_nxt_s;
            idle_r     <= (state_nxt_s == S_IDLE) && !next_valid_nxt_s;
            if (cnt_inc_s) begin
                records_sent_r <= records_sent_r + CNT_W'(1);
            end
        end
    end

    assign sample       = cur_rec_r[BYTE_W-1:0];
    assign sample_rdy   = (state_r == S_SEND);
    assign records_sent = records_sent_r;
    assign idle         = idle_r;

endmodule

// File: tb/tb_sample_serializer.sv
// Self-checking bench: byte-queue reference model, directed scenarios plus random traffic.
module tb_sample_serializer;

    localparam int RB = 6;
    localparam int CW = 4;

    logic            fx2_clk = 1'b0;
    logic            reset;
    logic            enable;
    logic [8*RB-1:0] rec_in;
    logic            rec_valid;
    logic            rec_ready;
    logic [7:0]      sample;
    logic            sample_rdy;
    logic            sample_ack;
    logic [CW-1:0]   records_sent;
    logic            idle;

    sample_serializer #(.RECORD_BYTES(RB), .CNT_W(CW)) dut (
        .fx2_clk      (fx2_clk),
        .reset        (reset),
        .enable       (enable),
        .rec_in       (rec_in),
        .rec_valid    (rec_valid),
        .rec_ready    (rec_ready),
        .sample       (sample),
        .sample_rdy   (sample_rdy),
        .sample_ack   (sample_ack),
        .records_sent (records_sent),
        .idle         (idle)
    );

    always #5 fx2_clk = ~fx2_clk;

    int checks = 0;
    int errors = 0;

    // Reference model: every byte still owed to the consumer, in output order.
    logic [7:0] exp_q[$];
    int         consumed = 0;
    int         sent = 0;
    int         sent_before = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs at the falling edge, compare, advance the model.
    task automatic step(input logic en, input logic vld, input logic [8*RB-1:0] d, input logic ack);
        logic rdy_m;
        enable     = en;
        rec_valid  = vld;
        rec_in     = d;
        sample_ack = ack;
        #1;
        rdy_m = en && (exp_q.size() <= RB) && !reset;
        if (reset) rdy_m = en;
        check("rec_ready", {63'd0, rec_ready}, {63'd0, rdy_m});
        check("sample_rdy", {63'd0, sample_rdy}, {63'd0, exp_q.size() != 0});
        check("idle", {63'd0, idle}, {63'd0, exp_q.size() == 0});
        check("records_sent", {60'd0, records_sent}, 64'(sent % 16));
        if (exp_q.size() != 0) check("sample", {56'd0, sample}, {56'd0, exp_q[0]});
        if (!reset) begin
            if (ack && exp_q.size() != 0) begin
                void'(exp_q.pop_front());
                consumed++;
                if (consumed == RB) begin
                    consumed = 0;
                    sent++;
                end
            end
            if (vld && rdy_m) begin
                for (int i = 0; i < RB; i++) exp_q.push_back(d[8*i +: 8]);
            end
        end
        @(posedge fx2_clk);
        @(negedge fx2_clk);
    endtask

    function automatic logic [8*RB-1:0] rnd_rec();
        return {$urandom_range(0, 65535), $urandom()};
    endfunction

    initial begin
        reset      = 1'b1;
        enable     = 1'b0;
        rec_valid  = 1'b0;
        rec_in     = '0;
        sample_ack = 1'b0;
        #1;
        check("reset_sample", {56'd0, sample}, 64'd0);
        check("reset_sample_rdy", {63'd0, sample_rdy}, 64'd0);
        check("reset_records_sent", {60'd0, records_sent}, 64'd0);
        check("reset_idle", {63'd0, idle}, 64'd1);
        @(negedge fx2_clk);
        @(negedge fx2_clk);
        reset = 1'b0;

        // Single record, ack every cycle.
        step(1'b1, 1'b1, 48'h060504030201, 1'b0);
        for (int i = 0; i < RB; i++) step(1'b1, 1'b0, '0, 1'b1);
        step(1'b1, 1'b0, '0, 1'b0);
        check("single_sent", {60'd0, records_sent}, 64'd1);
        check("single_idle", {63'd0, idle}, 64'd1);

        // Back-to-back: second record buffered while the first sends.
        step(1'b1, 1'b1, 48'h060504030201, 1'b0);
        step(1'b1, 1'b1, 48'h0C0B0A090807, 1'b1);
        for (int i = 0; i < 2*RB - 1; i++) step(1'b1, 1'b0, '0, 1'b1);
        step(1'b1, 1'b0, '0, 1'b0);
        check("b2b_sent", {60'd0, records_sent}, 64'd3);

        // Stalled consumer, then ack every other cycle.
        step(1'b1, 1'b1, 48'h060504030201, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, '0, 1'b0);
        for (int i = 0; i < 2*RB; i++) step(1'b1, 1'b0, '0, 1'(i % 2));

        // Enable drop with one record buffered after byte 02 is acked.
        sent_before = sent;
        step(1'b1, 1'b1, 48'h161514131211, 1'b0);
        step(1'b1, 1'b1, 48'h262524232221, 1'b1);
        step(1'b1, 1'b0, '0, 1'b1);
        for (int i = 0; i < 14; i++) step(1'b0, 1'b1, rnd_rec(), 1'b1);
        check("endrop_sent", 64'((records_sent - CW'(sent_before)) % 16), 64'd2);
        check("endrop_idle", {63'd0, idle}, 64'd1);

        // Reset after byte 03 is acked.
        step(1'b1, 1'b1, 48'h363534333231, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check("arst_sample_rdy", {63'd0, sample_rdy}, 64'd0);
        check("arst_records_sent", {60'd0, records_sent}, 64'd0);
        check("arst_idle", {63'd0, idle}, 64'd1);
        exp_q.delete();
        consumed = 0;
        sent = 0;
        @(negedge fx2_clk);
        step(1'b0, 1'b0, '0, 1'b1);
        reset = 1'b0;
        // Spurious acks while idle must change nothing.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, '0, 1'b1);

        // Counter wrap: 17 records on a 4-bit counter.
        for (int r = 0; r < 17; r++) begin
            step(1'b1, 1'b1, rnd_rec(), 1'b0);
            for (int i = 0; i < RB; i++) step(1'b1, 1'b0, '0, 1'b1);
        end
        check("wrap_sent", {60'd0, records_sent}, 64'd1);

        // Random traffic.
        for (int i = 0; i < 800; i++) begin
            step(1'(($urandom() % 8) != 0), 1'($urandom() % 2), rnd_rec(), 1'($urandom() % 2));
        end
        // Drain.
        for (int i = 0; i < 3*RB; i++) step(1'b0, 1'b0, '0, 1'b1);
        check("final_idle", {63'd0, idle}, 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sample_serializer.md
Name: sample_serializer

Overview:
- Byte serializer sitting directly upstream of the FX2 bidirectional interface's sample path.
- Accepts fixed-width timetag records from the tagger's record FIFO over a valid/ready handshake.
- Emits each record as a stream of bytes over the sample/sample_rdy/sample_ack handshake consumed by the FX2 interface.
- Holds one record in flight plus one buffered record, so back-to-back records stream without bubbles.

Parameters:
- RECORD_BYTES, 6, bytes per record; record width = 8*RECORD_BYTES.
- CNT_W, 32, width of the records_sent status counter.

Ports:
- fx2_clk  in  1  sole clock; all logic is rising-edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  when high, new records may be accepted.
- rec_in  in  8*RECORD_BYTES  record data; byte 0 is bits [7:0].
- rec_valid  in  1  rec_in is valid.
- rec_ready  out  1  block accepts rec_in this cycle.
- sample  out  8  current byte to the FX2 interface.
- sample_rdy  out  1  sample holds a valid byte.
- sample_ack  in  1  one-cycle pulse; the FX2 interface consumed the current byte.
- records_sent  out  CNT_W  count of fully transmitted records.
- idle  out  1  no record in flight and none buffered.

Behaviour:
- Interface decision: one clock (fx2_clk); reset is asynchronous and active-high (reset).
- Reset values: sample_rdy=0, sample=0, records_sent=0, idle=1. The byte index, current-record valid flag and next-record valid flag all clear.
- Storage:
  - cur_rec is a shift register with cur_valid and byte_idx (width clog2(RECORD_BYTES), minimum 1).
  - next_rec is a single holding register with next_valid.
- rec_ready = enable && !next_valid. This is combinational and must not depend on sample_ack.
- A record is accepted in any cycle where rec_valid && rec_ready.
- States:
  - IDLE: cur_valid=0.
  - SEND: cur_valid=1.
- IDLE transitions:
  - On accept, load rec_in into cur_rec, set byte_idx=0 and go to SEND.
  - Latency: accept at edge N gives sample_rdy=1 and sample=byte 0 after edge N.
- SEND outputs: sample = cur_rec[7:0] and sample_rdy=1, both registered.
- SEND, sample_ack on a non-last byte: shift cur_rec right by 8 and increment byte_idx. The next byte is valid the following cycle, and sample_rdy stays 1.
- SEND, sample_ack on the last byte (byte_idx=RECORD_BYTES-1): records_sent increments, wrapping modulo 2^CNT_W. Then:
  - if next_valid: move next_rec into cur_rec, clear next_valid, stay in SEND with no bubble;
  - else if an accept occurs the same cycle: load rec_in directly into cur_rec and stay in SEND;
  - else go to IDLE with sample_rdy=0.
- An accept in SEND that is not consumed by the last-byte rule above goes into next_rec and sets next_valid. rec_ready therefore drops the following cycle.
- sample_ack while sample_rdy=0 is ignored with no state change.
- sample_ack is a pulse: each cycle it is high consumes exactly one byte.
- enable low:
  - rec_ready=0 immediately.
  - The in-flight record and the buffered record still drain completely.
  - No record is ever truncated by enable.
- idle = !cur_valid && !next_valid, registered and consistent with sample_rdy.
- Reset mid-record: the partial record and the buffered record are discarded. All outputs return to their reset values, and no further bytes from that record are emitted after reset deasserts.
- Ordering: bytes leave LSB-first within a record, and records leave in acceptance order. No record is duplicated or dropped.

Decomposition:
- Shared package/include in config.v:
  - RECORD_BYTES default;
  - byte width constant 8;
  - state encodings S_IDLE=0 and S_SEND=1.
- One natural sub-module, record_holding_reg: the one-entry next_rec buffer with load and take strobes and a valid flag.

Test Plan:
- Single record: rec_in=48'h060504030201 with enable=1, then ack every cycle. Required: sample emits 01,02,03,04,05,06 on consecutive cycles; sample_rdy drops after the 6th ack; records_sent=1; idle=1.
- Back-to-back records: offer 48'h0C0B0A090807 while the first record is sending. Required: rec_ready=0 after it is buffered; bytes 01..06 then 07..0C with no cycle where sample_rdy=0; records_sent=2.
- Stalled consumer: hold sample_ack=0 for 10 cycles, then ack every other cycle. Required: sample stays 01 with sample_rdy=1 throughout the stall; subsequent bytes advance only on ack cycles.
- Enable drop: deassert enable after byte 02 is acked with one record buffered. Required: rec_ready=0 at once; remaining 4 bytes plus the buffered 6 bytes are all emitted; records_sent increases by 2; rec_valid is then ignored.
- Reset mid-record: assert reset after byte 03 is acked. Required: sample_rdy=0 and records_sent=0 asynchronously. After release with no new records, sample_rdy stays 0 and idle=1.
- Counter wrap: use CNT_W=4 and send 17 records. Required: records_sent reads 1. Also, a spurious sample_ack while idle leaves all state unchanged.
